// File: rtl/pad_serial_pkg.sv
// pad_serial_pkg: shared state encoding and default parameters for pad_serial_tx
package pad_serial_pkg;

  localparam int PAD_DATA_W_DEF       = 8;
  localparam int PAD_CLKS_PER_BIT_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/test_bus.sv
// test_bus: single-wire test link carrying one serial pad
interface test_bus;

  logic test_pad;

  modport tx (output test_pad);
  modport rx (input test_pad);

endinterface

// File: rtl/pad_bit_timer.sv
// pad_bit_timer: bit-period counter with a one-cycle strobe on the last cycle of each bit
module pad_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic run,
  output logic bit_done
);

  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_done = run && cnt == LAST;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (restart)
      cnt <= '0;
    else if (run)
      cnt <= bit_done ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/pad_serial_tx.sv
// pad_serial_tx: start/data/stop serial transmitter driving test_bus.test_pad
module pad_serial_tx
  import pad_serial_pkg::*;
#(
  parameter int DATA_W       = PAD_DATA_W_DEF,
  parameter int CLKS_PER_BIT = PAD_CLKS_PER_BIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              busy,
  test_bus.tx               iface
);

  localparam int IW = $clog2(DATA_W + 1);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_START = START;
  localparam logic [1:0] S_DATA  = DATA;
  localparam logic [1:0] S_STOP  = STOP;

  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_data_w
    $error("pad_serial_tx: DATA_W must be 1..32");
  end

  if (CLKS_PER_BIT < 1 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("pad_serial_tx: CLKS_PER_BIT must be 1..65535");
  end

  logic [1:0]        state;
  logic [1:0]        nxt;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_nxt;
  logic [IW-1:0]     idx;
  logic              hs;
  logic              bit_done;
  logic              last_bit;
  logic              data_step;

  assign tx_ready  = state == S_IDLE;
  assign busy      = !tx_ready;
  assign hs        = tx_valid && tx_ready;
  assign last_bit  = idx == IW'(DATA_W - 1);
  assign data_step = state == S_DATA && bit_done;

  pad_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .restart  (hs),
    .run      (state != S_IDLE),
    .bit_done (bit_done)
  );

  always_comb begin
    nxt       = state == S_IDLE  ? (hs ? S_START : S_IDLE) :
                !bit_done        ? state :
                state == S_START ? S_DATA :
                state == S_DATA  ? (last_bit ? S_STOP : S_DATA) :
                                   S_IDLE;
    shift_nxt = hs ? tx_data : data_step ? shift >> 1 : shift;
  end

  // The pad is computed from the next state so it changes on the same edge as the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      shift          <= '0;
      idx            <= '0;
      iface.test_pad <= 1'b1;
    end else begin
      state          <= nxt;
      shift          <= shift_nxt;
      idx            <= hs ? '0 : data_step ? idx + 1'b1 : idx;
      iface.test_pad <= nxt == S_START ? 1'b0 :
                        nxt == S_DATA  ? shift_nxt[0] :
                                         1'b1;
    end
  end

endmodule

// File: tb/tb_pad_serial_tx.sv
// tb_pad_serial_tx: randomized frame checks on three configurations against a waveform model
module tb_pad_serial_tx;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] data  = '0;
  int          sel   = 0;
  int          checks = 0;
  int          errs   = 0;
  logic [2:0]  rdy, bsy, pad;

  test_bus bus0 ();
  test_bus bus1 ();
  test_bus bus2 ();

  always #5 clk = ~clk;

  pad_serial_tx u0 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[7:0]), .tx_valid(valid && sel == 0),
    .tx_ready(rdy[0]), .busy(bsy[0]), .iface(bus0)
  );

  pad_serial_tx #(.CLKS_PER_BIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[7:0]), .tx_valid(valid && sel == 1),
    .tx_ready(rdy[1]), .busy(bsy[1]), .iface(bus1)
  );

  pad_serial_tx #(.DATA_W(1)) u2 (
    .clk(clk), .rst_n(rst_n), .tx_data(data[0:0]), .tx_valid(valid && sel == 2),
    .tx_ready(rdy[2]), .busy(bsy[2]), .iface(bus2)
  );

  assign pad = {bus2.test_pad, bus1.test_pad, bus0.test_pad};

  function automatic int cpb(input int s);
    return s == 1 ? 1 : 4;
  endfunction

  function automatic int dw(input int s);
    return s == 2 ? 1 : 8;
  endfunction

  // Expected pad level in the k-th cycle (1-based) after the handshake edge.
  function automatic logic exp_pad(input int s, input logic [31:0] d, input int k);
    int b;
    b = (k - 1) / cpb(s);
    return b == 0 ? 1'b0 : b <= dw(s) ? d[b-1] : 1'b1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checks++;
      if (pad[s] !== 1'b1 || bsy[s] !== 1'b0) begin
        errs++;
        $display("FAIL reset s=%0d pad=%b busy=%b required pad=1 busy=0", s, pad[s], bsy[s]);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdy !== 3'b111 || bsy !== 3'b000) begin
      errs++;
      $display("FAIL reset_release ready=%b busy=%b required 111 000", rdy, bsy);
    end
  endtask

  task automatic test_frame(input int s, input logic [31:0] d, input bit hold, input bit scramble);
    int len;
    len = (dw(s) + 2) * cpb(s);
    sel = s;
    valid = 1'b1;
    data = d;
    checks++;
    if (rdy[s] !== 1'b1 || pad[s] !== 1'b1) begin
      errs++;
      $display("FAIL idle_before s=%0d ready=%b pad=%b required 1 1", s, rdy[s], pad[s]);
    end
    @(posedge clk);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (!hold) valid = 1'b0;
      if (scramble) data = $urandom;
      checks++;
      if (pad[s] !== exp_pad(s, d, k) || bsy[s] !== 1'b1 || rdy[s] !== 1'b0) begin
        errs++;
        $display("FAIL frame s=%0d d=%h cycle=%0d pad=%b busy=%b ready=%b required pad=%b busy=1 ready=0",
                 s, d, k, pad[s], bsy[s], rdy[s], exp_pad(s, d, k));
      end
    end
    @(negedge clk);
    checks++;
    if (pad[s] !== 1'b1 || bsy[s] !== 1'b0 || rdy[s] !== 1'b1) begin
      errs++;
      $display("FAIL idle_after s=%0d pad=%b busy=%b ready=%b required 1 0 1", s, pad[s], bsy[s], rdy[s]);
    end
  endtask

  task automatic test_back_to_back();
    test_frame(0, 32'h3C, 1'b1, 1'b0);
    test_frame(0, 32'hC3, 1'b1, 1'b0);
    valid = 1'b0;
  endtask

  task automatic test_reset_midframe(input logic [31:0] d, input int at);
    sel = 0;
    valid = 1'b1;
    data = d;
    @(posedge clk);
    for (int k = 1; k < at; k++) begin
      @(negedge clk);
      valid = 1'b0;
      checks++;
      if (pad[0] !== exp_pad(0, d, k)) begin
        errs++;
        $display("FAIL pre_reset cycle=%0d pad=%b required %b", k, pad[0], exp_pad(0, d, k));
      end
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (pad[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      errs++;
      $display("FAIL reset_abort pad=%b busy=%b required 1 0", pad[0], bsy[0]);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 44; k++) begin
      @(negedge clk);
      checks++;
      if (pad[0] !== 1'b1 || rdy[0] !== 1'b1) begin
        errs++;
        $display("FAIL post_reset cycle=%0d pad=%b ready=%b required 1 1", k, pad[0], rdy[0]);
      end
    end
    test_frame(0, $urandom, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 9; i++) test_frame(i % 3, $urandom, 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_frame(0, 32'hA5, 1'b0, 1'b0);
    test_back_to_back();
    test_reset_midframe(32'hFF, 13);
    test_reset_midframe(32'h00, 6);
    test_frame(1, 32'h00, 1'b0, 1'b0);
    test_frame(0, 32'h5A, 1'b0, 1'b1);
    test_frame(2, 32'h1, 1'b0, 1'b0);
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule

// File: doc/pad_serial_tx.md
PAD_SERIAL_TX -- requirements
Module: pad_serial_tx

Interface
REQ-001 Parameter DATA_W, default 8: payload width in bits, legal range 1..32.
REQ-002 Parameter CLKS_PER_BIT, default 4: clock cycles per serial bit, legal range 1..65535.
REQ-003 Port clk, input, 1: the single clock; all state updates on rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port tx_data, input, DATA_W: payload word, sampled on handshake.
REQ-006 Port tx_valid, input, 1: payload offered.
REQ-007 Port tx_ready, output, 1: block accepts payload this cycle.
REQ-008 Port busy, output, 1: frame in progress.
REQ-009 Port iface, interface test_bus, -: block is the sole driver of iface.test_pad, the transmit end of the test_bus single-wire link.

Function
REQ-010 Frame SHALL be: start bit (0), DATA_W data bits LSB first, stop bit (1), each held exactly CLKS_PER_BIT cycles.
REQ-011 FSM states SHALL be IDLE, START, DATA, STOP; reset state IDLE.
REQ-012 IDLE: tx_ready=1, busy=0, test_pad=1; tx_valid&&tx_ready at an edge captures tx_data into a shift register and moves to START.
REQ-013 START: test_pad=0 from the cycle after the handshake for CLKS_PER_BIT cycles, then DATA.
REQ-014 DATA: test_pad=shift_reg[0]; after CLKS_PER_BIT cycles, shift right one place; after DATA_W bits, move to STOP.
REQ-015 STOP: test_pad=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-016 tx_ready SHALL be 1 only in IDLE; busy SHALL be exactly !tx_ready.
REQ-017 Frame length SHALL be (DATA_W+2)*CLKS_PER_BIT cycles, handshake edge to IDLE re-entry.
REQ-018 Back-to-back frames SHALL be separated by exactly one IDLE cycle, with test_pad=1 in that cycle.
REQ-019 tx_valid and tx_data changes while busy SHALL be ignored; the captured word is not altered mid-frame.
REQ-020 test_pad SHALL be a registered output with no combinational path from any input.
REQ-021 Bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap; CLKS_PER_BIT=1 SHALL give one cycle per bit with no stall.
REQ-022 Bit index counter SHALL be $clog2(DATA_W+1) bits wide and SHALL NOT wrap within a frame.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, test_pad=1, tx_ready=1 (while rst_n is high), busy=0, and all counters and the shift register to 0.
REQ-024 Reset asserted mid-frame SHALL abort the frame; no partial bits SHALL be emitted after rst_n rises.
REQ-025 First handshake SHALL be accepted on the first rising edge with rst_n high.

Structure
REQ-026 Package pad_serial_pkg SHALL hold the state enum typedef (tx_state_e) and default constants PAD_DATA_W_DEF=8 and PAD_CLKS_PER_BIT_DEF=4.
REQ-027 One sub-module, pad_bit_timer, SHALL hold the bit-period counter and emit a one-cycle bit_done strobe; it is restarted on entry to START.
REQ-028 Total RTL SHALL fit in 120-400 lines, including the package.

Verification
REQ-029 Defaults, send 0xA5 -> test_pad = 0, 1,0,1,0,0,1,0,1, 1, each bit 4 cycles; busy high for 40 cycles.
REQ-030 tx_valid held high, data 0x3C then 0xC3 -> two correct frames; test_pad=1 for exactly one idle cycle between them; tx_ready pulses once per frame.
REQ-031 rst_n low at cycle 13 of a 0xFF frame -> test_pad=1 at once; after release, no remaining frame bits; next handshake sends a clean frame.
REQ-032 CLKS_PER_BIT=1, DATA_W=8, send 0x00 -> 10-cycle frame: 0 then eight 0s then 1.
REQ-033 tx_data toggled randomly while busy during a 0x5A frame -> bits on test_pad still match 0x5A.
REQ-034 DATA_W=1, send 1 -> test_pad 0,1,1 at 4 cycles each; bit index stops at 1 with no wrap.
